// File: rtl/afg_pkg.sv
// Shared widths, state encoding and mode constants for the function-generator
// address path.
package afg_pkg;

    localparam int AFG_ACC_W   = 32;
    localparam int AFG_ADDR_W  = 14;
    localparam int AFG_BURST_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: registered sum with synchronous clear/enable.
// Exposes the top bits of the next sum and its carry so the owner can act on the same edge.
module phase_acc
    import afg_pkg::*;
#(
    parameter int ACC_W  = AFG_ACC_W,
    parameter int ADDR_W = AFG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ACC_W-1:0]  ftw,
    output logic [ADDR_W-1:0] phase_next,
    output logic              carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    assign {carry, acc_next} = {1'b0, acc} + {1'b0, ftw};
    assign phase_next        = acc_next[ACC_W-1 -: ADDR_W];

    // Clear dominates enable so a restart or stop lands on zero regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/addr_gen.sv
// DDS waveform-RAM address generator: playback FSM, shadow/active config,
// burst cycle counter and post-truncation phase offset.
module addr_gen
    import afg_pkg::*;
#(
    parameter int ACC_W   = AFG_ACC_W,
    parameter int ADDR_W  = AFG_ADDR_W,
    parameter int BURST_W = AFG_BURST_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               START,
    input  logic               STOP,
    input  logic               CFG_LOAD,
    input  logic               MODE,
    input  logic [ACC_W-1:0]   FTW,
    input  logic [ADDR_W-1:0]  PHASE_OFS,
    input  logic [BURST_W-1:0] BURST_CNT,
    output logic [ADDR_W-1:0]  ADDR_OUT,
    output logic               ADDR_VALID,
    output logic               WRAP,
    output logic               BUSY,
    output logic               DONE,
    output state_t             state_dbg
);

    state_t state_q, state_n;

    logic               sh_mode, act_mode, act_mode_n;
    logic [ACC_W-1:0]   sh_ftw, act_ftw, act_ftw_n;
    logic [ADDR_W-1:0]  sh_ofs, act_ofs, act_ofs_n;
    logic [BURST_W-1:0] sh_cnt, act_cnt, act_cnt_n;
    logic               pend_q, pend_n;
    logic [BURST_W-1:0] wcnt_q, wcnt_n, wcnt_inc, burst_len;

    logic [ADDR_W-1:0]  addr_n;
    logic               valid_n, wrap_n, done_n, busy_n;
    logic               acc_clr, acc_en, carry;
    logic [ADDR_W-1:0]  phase_next;
    logic               start_go;

    assign start_go  = START && !STOP;
    assign wcnt_inc  = wcnt_q + BURST_W'(1);
    assign burst_len = (act_cnt == '0) ? BURST_W'(1) : act_cnt;
    assign state_dbg = state_q;

    phase_acc #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_acc (
        .clk        (Clock),
        .rst        (Reset),
        .clr        (acc_clr),
        .en         (acc_en),
        .ftw        (act_ftw),
        .phase_next (phase_next),
        .carry      (carry)
    );

    // ADDR_VALID is a valid-only stream: no backpressure, one new sample
    // every cycle it is high; consumers must take it on that cycle.
    always_comb begin
        state_n    = state_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        act_mode_n = act_mode;
        act_ftw_n  = act_ftw;
        act_ofs_n  = act_ofs;
        act_cnt_n  = act_cnt;
        pend_n     = pend_q;
        wcnt_n     = wcnt_q;
        addr_n     = ADDR_OUT;
        valid_n    = 1'b0;
        wrap_n     = 1'b0;
        done_n     = 1'b0;
        busy_n     = 1'b0;

        if (start_go) begin
            // A same-cycle CFG_LOAD is forwarded straight into the active set.
            state_n    = ST_RUN;
            acc_clr    = 1'b1;
            act_mode_n = CFG_LOAD ? MODE      : sh_mode;
            act_ftw_n  = CFG_LOAD ? FTW       : sh_ftw;
            act_ofs_n  = CFG_LOAD ? PHASE_OFS : sh_ofs;
            act_cnt_n  = CFG_LOAD ? BURST_CNT : sh_cnt;
            pend_n     = 1'b0;
            wcnt_n     = '0;
            addr_n     = act_ofs_n;
            valid_n    = 1'b1;
            busy_n     = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (STOP) begin
                state_n = ST_IDLE;
                acc_clr = 1'b1;
                pend_n  = 1'b0;
            end else begin
                acc_en  = 1'b1;
                valid_n = 1'b1;
                busy_n  = 1'b1;
                wrap_n  = carry;
                addr_n  = phase_next + act_ofs;
                if (CFG_LOAD) begin
                    pend_n = 1'b1;
                end
                if (carry) begin
                    // Pending config takes effect only at a waveform-cycle boundary.
                    if (pend_q) begin
                        act_mode_n = sh_mode;
                        act_ftw_n  = sh_ftw;
                        act_ofs_n  = sh_ofs;
                        act_cnt_n  = sh_cnt;
                        pend_n     = CFG_LOAD;
                    end
                    if (act_mode == MODE_BURST) begin
                        wcnt_n = wcnt_inc;
                        if (wcnt_inc == burst_len) begin
                            state_n = ST_IDLE;
                            acc_clr = 1'b1;
                            valid_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pend_n  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sh_mode    <= MODE_CONT;
            sh_ftw     <= '0;
            sh_ofs     <= '0;
            sh_cnt     <= '0;
            act_mode   <= MODE_CONT;
            act_ftw    <= '0;
            act_ofs    <= '0;
            act_cnt    <= '0;
            pend_q     <= 1'b0;
            wcnt_q     <= '0;
            ADDR_OUT   <= '0;
            ADDR_VALID <= 1'b0;
            WRAP       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            if (CFG_LOAD) begin
                sh_mode <= MODE;
                sh_ftw  <= FTW;
                sh_ofs  <= PHASE_OFS;
                sh_cnt  <= BURST_CNT;
            end
            act_mode   <= act_mode_n;
            act_ftw    <= act_ftw_n;
            act_ofs    <= act_ofs_n;
            act_cnt    <= act_cnt_n;
            pend_q     <= pend_n;
            wcnt_q     <= wcnt_n;
            ADDR_OUT   <= addr_n;
            ADDR_VALID <= valid_n;
            WRAP       <= wrap_n;
            BUSY       <= busy_n;
            DONE       <= done_n;
        end
    end

endmodule

// File: tb/tb_addr_gen.sv
// Directed bench for addr_gen: hand-computed address sequences checked with
// immediate assertions after each rising edge.
module tb_addr_gen;
    import afg_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        START, STOP, CFG_LOAD, MODE;
    logic [31:0] FTW;
    logic [13:0] PHASE_OFS;
    logic [15:0] BURST_CNT;
    logic [13:0] ADDR_OUT;
    logic        ADDR_VALID, WRAP, BUSY, DONE;
    state_t      state_dbg;

    int    n_cmp = 0;
    int    n_err = 0;
    logic  clk_en = 1'b1;

    localparam logic [31:0] F30 = 32'h4000_0000;
    localparam logic [31:0] F31 = 32'h8000_0000;
    localparam logic [31:0] F18 = 32'h0004_0000;

    addr_gen dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .START      (START),
        .STOP       (STOP),
        .CFG_LOAD   (CFG_LOAD),
        .MODE       (MODE),
        .FTW        (FTW),
        .PHASE_OFS  (PHASE_OFS),
        .BURST_CNT  (BURST_CNT),
        .ADDR_OUT   (ADDR_OUT),
        .ADDR_VALID (ADDR_VALID),
        .WRAP       (WRAP),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .state_dbg  (state_dbg)
    );

    always #5 if (clk_en) Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [13:0] a, input logic v,
                           input logic w, input logic b, input logic d);
        chk({tag, ".addr"}, 32'(ADDR_OUT), 32'(a));
        chk({tag, ".valid"}, 32'(ADDR_VALID), 32'(v));
        chk({tag, ".wrap"}, 32'(WRAP), 32'(w));
        chk({tag, ".busy"}, 32'(BUSY), 32'(b));
        chk({tag, ".done"}, 32'(DONE), 32'(d));
    endtask

    task automatic cfg(input logic m, input logic [31:0] f, input logic [13:0] o,
                       input logic [15:0] c);
        MODE = m;
        FTW = f;
        PHASE_OFS = o;
        BURST_CNT = c;
    endtask

    initial begin
        logic [13:0] cont_seq [9];
        logic        cont_wrap [9];
        logic [13:0] ofs_seq [6];
        cont_seq  = '{14'd0, 14'd4096, 14'd8192, 14'd12288, 14'd0,
                      14'd4096, 14'd8192, 14'd12288, 14'd0};
        cont_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ofs_seq   = '{14'd16380, 14'd16381, 14'd16382, 14'd16383, 14'd0, 14'd1};

        // Reset
        Reset = 1'b1;
        START = 1'b0;
        STOP = 1'b0;
        CFG_LOAD = 1'b0;
        cfg(1'b0, 32'd0, 14'd0, 16'd0);
        #3;
        chk_out("reset", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        Reset = 1'b0;
        tick();

        // Continuous, FTW = 2^30
        cfg(MODE_CONT, F30, 14'd0, 16'd0);
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        chk("cfg_idle.busy", 32'(BUSY), 32'd0);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk_out($sformatf("cont[%0d]", i), cont_seq[i], 1'b1, cont_wrap[i], 1'b1, 1'b0);
        end
        chk("cont.state", 32'(state_dbg), 32'(ST_RUN));

        // Restart in RUN, then deferred FTW change to 2^31
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_out("restart", 14'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("defer0", 14'd4096, 1'b1, 1'b0, 1'b1, 1'b0);
        cfg(MODE_CONT, F31, 14'd0, 16'd0);
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        chk_out("defer1", 14'd8192, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("defer2", 14'd12288, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("defer3", 14'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("defer4", 14'd8192, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("defer5", 14'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // START and STOP together: STOP wins
        START = 1'b1;
        STOP = 1'b1;
        tick();
        START = 1'b0;
        STOP = 1'b0;
        chk_out("stopwin", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stopwin.state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        chk("idle.valid", 32'(ADDR_VALID), 32'd0);

        // Phase offset with CFG_LOAD and START in the same cycle
        cfg(MODE_CONT, F18, 14'd16380, 16'd0);
        CFG_LOAD = 1'b1;
        START = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        START = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            chk_out($sformatf("ofs[%0d]", i), ofs_seq[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk_out("ofs_stop", 14'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_out("ofs_restart", 14'd16380, 1'b1, 1'b0, 1'b1, 1'b0);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;

        // Burst of 2 waveform cycles
        cfg(MODE_BURST, F30, 14'd0, 16'd2);
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk_out($sformatf("burst[%0d]", i), cont_seq[i], 1'b1, cont_wrap[i], 1'b1, 1'b0);
        end
        tick();
        chk("burst_end.valid", 32'(ADDR_VALID), 32'd0);
        chk("burst_end.wrap", 32'(WRAP), 32'd1);
        chk("burst_end.done", 32'(DONE), 32'd1);
        chk("burst_end.busy", 32'(BUSY), 32'd0);
        chk("burst_end.state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        chk("burst_after.done", 32'(DONE), 32'd0);
        chk("burst_after.wrap", 32'(WRAP), 32'd0);

        // BURST_CNT = 0 behaves as one cycle
        cfg(MODE_BURST, F31, 14'd0, 16'd0);
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_out("b0[0]", 14'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("b0[1]", 14'd8192, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("b0_end.valid", 32'(ADDR_VALID), 32'd0);
        chk("b0_end.done", 32'(DONE), 32'd1);
        chk("b0_end.wrap", 32'(WRAP), 32'd1);

        // Asynchronous reset mid-RUN with the clock stopped
        cfg(MODE_CONT, F30, 14'd5, 16'd0);
        CFG_LOAD = 1'b1;
        START = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
        START = 1'b0;
        chk_out("rr[0]", 14'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("rr[1]", 14'd4101, 1'b1, 1'b0, 1'b1, 1'b0);
        clk_en = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk_out("async_rst", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.state", 32'(state_dbg), 32'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
